block_accumulator: RTL and testbench

BLOCK_ACCUMULATOR -- requirements
Module: block_accumulator

---
 rtl/block_acc_pkg.sv | 17 +
 rtl/acc_add_sat.sv | 28 ++
 rtl/block_accumulator.sv | 90 +++++++++
 tb/tb_block_accumulator.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/block_acc_pkg.sv
// Shared types and default parameters for the block accumulator.
package block_acc_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StAccum = 2'd1,
    StHold  = 2'd2
  } acc_state_e;

  localparam int unsigned DefDataW    = 8;
  localparam int unsigned DefSumW     = 10;
  localparam int unsigned DefBlockLen = 8;

  // Wide enough for the largest legal block length (255).
  localparam int unsigned CntW = 8;

endpackage

// File: rtl/acc_add_sat.sv
// Combinational accumulator adder with overflow detect.
// Define ACC_SATURATE_EN to clamp at the maximum instead of wrapping.
module acc_add_sat
  import block_acc_pkg::*;
#(
  parameter int unsigned DATA_W = DefDataW,
  parameter int unsigned SUM_W  = DefSumW
) (
  input  logic [SUM_W-1:0]  sum_in,
  input  logic [DATA_W-1:0] data_in,
  output logic [SUM_W-1:0]  sum_out,
  output logic              ovf_out
);

  logic [SUM_W:0] full;

  always_comb begin
    full    = {1'b0, sum_in} + (SUM_W+1)'(data_in);
    ovf_out = full[SUM_W];
`ifdef ACC_SATURATE_EN
    // A clamped sum plus any nonzero sample overflows again, so it stays clamped.
    sum_out = ovf_out ? {SUM_W{1'b1}} : full[SUM_W-1:0];
`else
    sum_out = full[SUM_W-1:0];
`endif
  end

endmodule

// File: rtl/block_accumulator.sv
// Sums BLOCK_LEN unsigned samples and presents the result over a valid/ready handshake.
// Saturating vs. wrapping accumulation is selected by ACC_SATURATE_EN (see acc_add_sat).
module block_accumulator
  import block_acc_pkg::*;
#(
  parameter int unsigned DATA_W    = DefDataW,
  parameter int unsigned SUM_W     = DefSumW,
  parameter int unsigned BLOCK_LEN = DefBlockLen
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [SUM_W-1:0]  out_sum,
  output logic              out_overflow
);

  acc_state_e       state_q, state_d;
  logic [SUM_W-1:0] sum_q, sum_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             ovf_q, ovf_d;

  logic             accept;
  logic [SUM_W-1:0] add_sum;
  logic             add_ovf;

  acc_add_sat #(
    .DATA_W (DATA_W),
    .SUM_W  (SUM_W)
  ) u_add (
    .sum_in  (sum_q),
    .data_in (in_data),
    .sum_out (add_sum),
    .ovf_out (add_ovf)
  );

  // Handshake outputs are pure functions of state: no combinational in->out paths.
  assign in_ready     = (state_q != StHold);
  assign out_valid    = (state_q == StHold);
  assign out_sum      = out_valid ? sum_q : '0;
  assign out_overflow = out_valid & ovf_q;
  assign accept       = in_valid & in_ready;

  always_comb begin
    state_d = state_q;
    sum_d   = sum_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          sum_d   = SUM_W'(in_data);
          count_d = CntW'(1);
          ovf_d   = 1'b0;
          state_d = (BLOCK_LEN == 1) ? StHold : StAccum;
        end
      end
      StAccum: begin
        if (accept) begin
          sum_d   = add_sum;
          count_d = count_q + CntW'(1);
          ovf_d   = ovf_q | add_ovf;
          if (count_q == CntW'(BLOCK_LEN - 1)) state_d = StHold;
        end
      end
      StHold: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      sum_q   <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sum_q   <= sum_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule

// File: tb/tb_block_accumulator.sv
// Scoreboard bench for block_accumulator: stimulus pushes expected results,
// a monitor pops and compares on every output transfer.
module tb_block_accumulator;

  localparam int unsigned DATA_W    = 8;
  localparam int unsigned SUM_W     = 10;
  localparam int unsigned BLOCK_LEN = 8;

  typedef struct packed {
    logic [SUM_W-1:0] sum;
    logic             ovf;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [SUM_W-1:0]  out_sum;
  logic              out_overflow;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  logic prev_xfer = 1'b0;

  block_accumulator #(
    .DATA_W    (DATA_W),
    .SUM_W     (SUM_W),
    .BLOCK_LEN (BLOCK_LEN)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_sum      (out_sum),
    .out_overflow (out_overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 just after the sample was accepted.
  task automatic send(input logic [DATA_W-1:0] d);
    int n;
    n        = 0;
    in_valid = 1'b1;
    in_data  = d;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: in_ready stuck at 0, expected 1");
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic push(input logic [SUM_W-1:0] s, input logic o);
    exp_t e;
    e.sum = s;
    e.ovf = o;
    exp_q.push_back(e);
  endtask

  // Monitor: compare every completed transfer against the scoreboard.
  always @(negedge clk) begin
    if (rst_n) begin
      if (prev_xfer) chk("out_valid_after_xfer", 32'(out_valid), 32'd0);
      if (!out_valid) chk("out_sum_zero_outside_hold", 32'(out_sum), 32'd0);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: got sum 0x%0h, expected no output", out_sum);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("out_sum", 32'(out_sum), 32'(e.sum));
          chk("out_overflow", 32'(out_overflow), 32'(e.ovf));
        end
      end
      prev_xfer <= out_valid && out_ready;
    end else begin
      prev_xfer <= 1'b0;
    end
  end

  initial begin
    int n;
    logic [SUM_W-1:0] ovf_sum;
`ifdef ACC_SATURATE_EN
    ovf_sum = 10'h3FF;
`else
    ovf_sum = 10'h3F8;
`endif
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_sum", 32'(out_sum), 32'd0);
    chk("rst_out_overflow", 32'(out_overflow), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;

    // Normal block, back-to-back
    push(10'h208, 1'b0);
    send(8'hAA); send(8'h55); send(8'hFF); send(8'h00);
    send(8'h01); send(8'h02); send(8'h03); send(8'h04);
    @(negedge clk);
    chk("normal_latency", 32'(out_valid), 32'd1);
    @(posedge clk);
    #1;

    // Overflow block
    push(ovf_sum, 1'b1);
    for (int i = 0; i < 8; i++) send(8'hFF);
    @(negedge clk);
    chk("ovf_latency", 32'(out_valid), 32'd1);
    @(posedge clk);
    #1;

    // Backpressure: 0x10..0x17 sums to 156
    out_ready = 1'b0;
    push(10'd156, 1'b0);
    for (int i = 0; i < 8; i++) send(8'(8'h10 + i));
    @(negedge clk);
    chk("bp_latency", 32'(out_valid), 32'd1);
    in_valid = 1'b1;
    in_data  = 8'h77;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      chk("bp_out_sum", 32'(out_sum), 32'd156);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
    end
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("bp_idle_in_ready", 32'(in_ready), 32'd1);
    chk("bp_idle_out_valid", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;
    push(10'd24, 1'b0);
    for (int i = 0; i < 8; i++) send(8'h03);
    @(posedge clk);
    #1;

    // Gapped input
    push(10'd8, 1'b0);
    for (int i = 0; i < 8; i++) begin
      send(8'h01);
      if (i < 7) begin
        @(posedge clk);
        #1;
      end
    end
    @(negedge clk);
    chk("gap_latency", 32'(out_valid), 32'd1);
    @(posedge clk);
    #1;

    // Mid-block reset discards the partial block
    for (int i = 0; i < 3; i++) send(8'h10);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    push(10'd8, 1'b0);
    for (int i = 0; i < 8; i++) send(8'h01);

    // Drain scoreboard
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending results, expected 0", exp_q.size());
    end
    repeat (5) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
